// File: rtl/piso_shift_ctrl.sv
// Parallel-in/serial-out shift register with a load handshake, shift stall and selectable bit order.
// Back-to-back words are accepted on the last bit of the current word with no idle bubble.
module piso_shift_ctrl #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    input  logic             ser_in,
    output logic             sout,
    output logic             sout_valid,
    output logic             last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] shreg_r;
    logic [CW-1:0]    cnt_r;
    logic             sout_r;
    logic             sout_valid_r;
    logic             last_r;

    logic             at_last_s;
    logic             take_s;
    logic [CW-1:0]    cnt_nxt_s;
    logic [WIDTH-1:0] shreg_nxt_s;

    // Bit presented at the output end of a word image.
    function automatic logic out_bit(input logic [WIDTH-1:0] word);
        if (MSB_FIRST) begin
            return word[WIDTH-1];
        end else begin
            return word[0];
        end
    endfunction

    // Word image after moving one bit out; the fill bit enters the far end.
    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] word, input logic fill);
        if (MSB_FIRST) begin
            return {word[WIDTH-2:0], fill};
        end else begin
            return {fill, word[WIDTH-1:1]};
        end
    endfunction

    assign at_last_s   = (state_r == SHIFT) && (cnt_r == CNT_LAST);
    assign load_ready  = (state_r == IDLE) || (at_last_s && shift_en);
    assign take_s      = load_valid && load_ready;
    assign cnt_nxt_s   = cnt_r + CW'(1);
    assign shreg_nxt_s = shift_word(shreg_r, ser_in);

    assign sout        = sout_r;
    assign sout_valid  = sout_valid_r;
    assign last        = last_r;
    assign busy        = sout_valid_r;

    // Control FSM, shift register and registered serial outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            shreg_r      <= '0;
            cnt_r        <= '0;
            sout_r       <= 1'b0;
            sout_valid_r <= 1'b0;
            last_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (take_s) begin
                        state_r      <= SHIFT;
                        shreg_r      <= load_data;
                        cnt_r        <= '0;
                        sout_r       <= out_bit(load_data);
                        sout_valid_r <= 1'b1;
                        last_r       <= 1'b0;
                    end else begin
                        state_r      <= IDLE;
                    end
                end
                SHIFT: begin
                    if (!shift_en) begin
                        state_r <= SHIFT;
                    end else if (!at_last_s) begin
                        shreg_r <= shreg_nxt_s;
                        cnt_r   <= cnt_nxt_s;
                        sout_r  <= out_bit(shreg_nxt_s);
                        last_r  <= (cnt_nxt_s == CNT_LAST);
                    end else if (take_s) begin
                        // Reload on the final bit so the next word follows without a gap.
                        shreg_r      <= load_data;
                        cnt_r        <= '0;
                        sout_r       <= out_bit(load_data);
                        sout_valid_r <= 1'b1;
                        last_r       <= 1'b0;
                    end else begin
                        state_r      <= IDLE;
                        cnt_r        <= '0;
                        sout_r       <= 1'b0;
                        sout_valid_r <= 1'b0;
                        last_r       <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    shreg_r      <= '0;
                    cnt_r        <= '0;
                    sout_r       <= 1'b0;
                    sout_valid_r <= 1'b0;
                    last_r       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_shift_ctrl.sv
// Self-checking bench: three serialiser configurations run in lockstep against a word/index model,
// with a directed vector table and hand-written stall, back-to-back, reset and reassembly sequences.
module tb_piso_shift_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_valid = 1'b0;
    logic [31:0] ld = 32'd0;
    logic        shift_en = 1'b0;
    logic        ser_in = 1'b0;
    logic [2:0]  rdy_a, sout_a, sv_a, last_a, busy_a;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    piso_shift_ctrl #(.WIDTH(4), .MSB_FIRST(1'b1)) u_m4 (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(rdy_a[0]),
        .load_data(ld[3:0]), .shift_en(shift_en), .ser_in(ser_in), .sout(sout_a[0]),
        .sout_valid(sv_a[0]), .last(last_a[0]), .busy(busy_a[0]));
    piso_shift_ctrl #(.WIDTH(4), .MSB_FIRST(1'b0)) u_l4 (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(rdy_a[1]),
        .load_data(ld[3:0]), .shift_en(shift_en), .ser_in(ser_in), .sout(sout_a[1]),
        .sout_valid(sv_a[1]), .last(last_a[1]), .busy(busy_a[1]));
    piso_shift_ctrl #(.WIDTH(8), .MSB_FIRST(1'b1)) u_m8 (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(rdy_a[2]),
        .load_data(ld[7:0]), .shift_en(shift_en), .ser_in(ser_in), .sout(sout_a[2]),
        .sout_valid(sv_a[2]), .last(last_a[2]), .busy(busy_a[2]));

    // Reference model: the accepted word plus the index of the bit currently on sout.
    int          m_w[3]   = '{4, 4, 8};
    bit          m_msb[3] = '{1'b1, 1'b0, 1'b1};
    bit          m_act[3];
    logic [31:0] m_word[3];
    int          m_pos[3];

    function automatic bit m_sout(int i);
        if (!m_act[i]) return 1'b0;
        return m_msb[i] ? m_word[i][m_w[i]-1-m_pos[i]] : m_word[i][m_pos[i]];
    endfunction

    function automatic bit m_last(int i);
        return m_act[i] && (m_pos[i] == m_w[i] - 1);
    endfunction

    function automatic bit m_ready(int i, bit se);
        return !m_act[i] || (se && m_pos[i] == m_w[i] - 1);
    endfunction

    task automatic m_step(int i, bit v, logic [31:0] d, bit se);
        if (v && m_ready(i, se)) begin
            m_word[i] = d & 32'((64'd1 << m_w[i]) - 64'd1);
            m_pos[i]  = 0;
            m_act[i]  = 1'b1;
        end else if (m_act[i] && se) begin
            if (m_pos[i] == m_w[i] - 1) m_act[i] = 1'b0;
            else m_pos[i] = m_pos[i] + 1;
        end
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, compare against the model, then advance the model past posedge.
    task automatic tick(bit v, logic [31:0] d, bit se, bit si);
        @(negedge clk);
        load_valid = v;
        ld = d;
        shift_en = se;
        ser_in = si;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("model_sout[%0d]", i), 32'(sout_a[i]), 32'(m_sout(i)));
            chk($sformatf("model_valid[%0d]", i), 32'(sv_a[i]), 32'(m_act[i]));
            chk($sformatf("model_busy[%0d]", i), 32'(busy_a[i]), 32'(m_act[i]));
            chk($sformatf("model_last[%0d]", i), 32'(last_a[i]), 32'(m_last(i)));
            chk($sformatf("model_ready[%0d]", i), 32'(rdy_a[i]), 32'(m_ready(i, se)));
        end
        for (int i = 0; i < 3; i++) m_step(i, v, d, se);
    endtask

    task automatic drain();
        for (int k = 0; k < 10; k++) tick(1'b0, 32'd0, 1'b1, 1'($urandom));
    endtask

    typedef struct {
        bit       v;
        logic [3:0] d;
        bit       se;
        bit       e_m;
        bit       e_l;
        bit       e_sv;
        bit       e_last;
        bit       e_rdy;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [7:0] asm_w;
        int         nbits;
        bit         se_r;
        bit         stall_se[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        bit         stall_exp[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        bit         b2b_exp[8]   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        bit         b2b_rdy[8]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        // 4'b1011: MSB-first 1,0,1,1; LSB-first 1,1,0,1; idle afterwards.
        tbl[0] = '{1'b1, 4'b1011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        for (int i = 0; i < 3; i++) begin
            m_act[i] = 1'b0;
            m_word[i] = 32'd0;
            m_pos[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_sout[%0d]", i), 32'(sout_a[i]), 32'd0);
            chk($sformatf("rst_valid[%0d]", i), 32'(sv_a[i]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 6; k++) begin
            tick(tbl[k].v, {28'd0, tbl[k].d}, tbl[k].se, 1'b1);
            chk($sformatf("tbl%0d_sout_msb", k), 32'(sout_a[0]), 32'(tbl[k].e_m));
            chk($sformatf("tbl%0d_sout_lsb", k), 32'(sout_a[1]), 32'(tbl[k].e_l));
            chk($sformatf("tbl%0d_valid", k), 32'(sv_a[0]), 32'(tbl[k].e_sv));
            chk($sformatf("tbl%0d_last", k), 32'(last_a[0]), 32'(tbl[k].e_last));
            chk($sformatf("tbl%0d_ready", k), 32'(rdy_a[0]), 32'(tbl[k].e_rdy));
        end

        // Stall after the first bit of 4'b1100.
        tick(1'b1, 32'hC, 1'b1, 1'b0);
        for (int k = 0; k < 7; k++) begin
            tick(1'b0, 32'd0, stall_se[k], 1'b1);
            chk($sformatf("stall%0d_sout", k), 32'(sout_a[0]), 32'(stall_exp[k]));
            chk($sformatf("stall%0d_valid", k), 32'(sv_a[0]), 32'd1);
            chk($sformatf("stall%0d_last", k), 32'(last_a[0]), 32'(k == 6));
        end
        tick(1'b0, 32'd0, 1'b1, 1'b0);
        chk("stall_idle", 32'(sv_a[0]), 32'd0);
        drain();

        // Back-to-back 4'hA then 4'h5 with the second word held through the last bit.
        tick(1'b1, 32'hA, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            tick(k < 4, 32'h5, 1'b1, 1'b1);
            chk($sformatf("b2b%0d_sout", k), 32'(sout_a[0]), 32'(b2b_exp[k]));
            chk($sformatf("b2b%0d_valid", k), 32'(sv_a[0]), 32'd1);
            chk($sformatf("b2b%0d_ready", k), 32'(rdy_a[0]), 32'(b2b_rdy[k]));
        end
        drain();

        // Asynchronous reset while on the last bit of a word.
        tick(1'b1, 32'hFF, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) tick(1'b0, 32'd0, 1'b1, 1'b1);
        tick(1'b0, 32'd0, 1'b0, 1'b1);
        chk("pre_rst_last", 32'(last_a[0]), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("async_sout[%0d]", i), 32'(sout_a[i]), 32'd0);
            chk($sformatf("async_valid[%0d]", i), 32'(sv_a[i]), 32'd0);
            chk($sformatf("async_last[%0d]", i), 32'(last_a[i]), 32'd0);
            m_act[i] = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) chk($sformatf("post_rst_ready[%0d]", i), 32'(rdy_a[i]), 32'd1);
        drain();

        // 8'hC3 with random stalls and random ignored loads; reassemble the consumed bits.
        tick(1'b1, 32'hC3, 1'b1, 1'b0);
        asm_w = 8'd0;
        nbits = 0;
        for (int k = 0; k < 200; k++) begin
            se_r = ($urandom_range(0, 2) != 0);
            tick(1'($urandom), $urandom, se_r, 1'($urandom));
            if (sv_a[2] && se_r) begin
                asm_w = {asm_w[6:0], sout_a[2]};
                nbits++;
                if (last_a[2]) break;
            end
        end
        chk("c3_bits", 32'(nbits), 32'd8);
        chk("c3_word", 32'(asm_w), 32'hC3);

        // Free-running random traffic checked only by the model.
        for (int k = 0; k < 400; k++)
            tick(1'($urandom), $urandom, ($urandom_range(0, 3) != 0), 1'($urandom));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
